// File: rtl/rca_multicycle_addsub.sv
// rca_multicycle_addsub: multi-cycle ripple-carry adder/subtractor.
// Adds one CHUNK-bit slice per clock and keeps the inter-slice carry in a
// register, so a wide add never needs a full-width carry chain in one cycle.
// Valid/ready handshakes are used on both the operand and result sides.
module rca_multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of slices; guarded so a bad CHUNK cannot divide by zero before
    // the parameter check below reports it.
    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam bit PARAMS_OK = (CHUNK >= 1) && (WIDTH >= 2) &&
                               ((WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) == 0);

    // Refuse to elaborate with a slice width that does not tile the operand.
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("rca_multicycle_addsub: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;        // operand A
    logic [WIDTH-1:0] b_reg;        // effective operand B (inverted for subtract)
    logic             carry_reg;    // carry into the slice being processed
    logic [CNT_W-1:0] cnt_reg;      // index of the slice being processed
    logic [WIDTH-1:0] res_reg;      // partial result, built one slice at a time
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    // Slice datapath
    int               chunk_base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK:0]   c_chain;
    logic             chunk_cout;
    logic             carry_msb_in;
    logic [WIDTH-1:0] res_next;

    // Select the operand slice addressed by the chunk counter.
    always_comb begin
        chunk_base = int'(cnt_reg) * CHUNK;
        a_chunk    = a_reg[chunk_base +: CHUNK];
        b_chunk    = b_reg[chunk_base +: CHUNK];
    end

    // Bit-level ripple across one slice; exposing every internal carry gives
    // the carry into the MSB for free on the last slice.
    assign c_chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign s_chunk[gi]   = a_chunk[gi] ^ b_chunk[gi] ^ c_chain[gi];
            assign c_chain[gi+1] = (a_chunk[gi] & b_chunk[gi]) |
                                   (c_chain[gi] & (a_chunk[gi] ^ b_chunk[gi]));
        end
    endgenerate

    assign chunk_cout   = c_chain[CHUNK];
    assign carry_msb_in = c_chain[CHUNK-1];

    // Merge the freshly computed slice into the partial result.
    always_comb begin
        res_next                        = res_reg;
        res_next[chunk_base +: CHUNK]   = s_chunk;
    end

    // Control FSM with registered result outputs; reset discards any
    // operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            res_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as a + ~b + ~cin so one adder serves both.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? ~cin : cin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= chunk_cout;
                    if (cnt_reg == LAST_CNT) begin
                        sum_reg       <= res_next;
                        cout_reg      <= chunk_cout;
                        ovf_reg       <= carry_msb_in ^ chunk_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Result holds until the consumer takes it.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rca_multicycle_addsub.sv
// Bench for rca_multicycle_addsub: directed vectors on the 16/4 build,
// exhaustive 4/4 sweep and a back-to-back random stream on a 32/8 build.
module tb_rca_multicycle_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 16-bit, 4-bit slices
    logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic        cin16 = 0, sub16 = 0, cout16, ovf16;

    // 4-bit single-pass
    logic        in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 1;
    logic [3:0]  a4 = 0, b4 = 0, sum4;
    logic        cin4 = 0, sub4 = 0, cout4, ovf4;

    // 32-bit, 8-bit slices
    logic        in_valid32 = 0, in_ready32, out_valid32, out_ready32 = 1;
    logic [31:0] a32 = 0, b32 = 0, sum32;
    logic        cin32 = 0, sub32 = 0, cout32, ovf32;

    rca_multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    rca_multicycle_addsub #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4));

    rca_multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32));

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum[63:0]} for a w-bit add/sub.
    // Overflow from operand/result signs, independent of carry bookkeeping.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] ta,
                                              input logic [63:0] tb, input logic tc,
                                              input logic ts);
        logic [63:0] mask, eb, s;
        logic [64:0] full;
        logic        ec, co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        eb   = (ts ? ~tb : tb) & mask;
        ec   = ts ? ~tc : tc;
        full = {1'b0, ta & mask} + {1'b0, eb} + {64'd0, ec};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (ta[w-1] == eb[w-1]) && (s[w-1] != ta[w-1]);
        return {ov, co, s};
    endfunction

    // One transaction on the 16-bit instance with hand-computed expectations.
    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo, input bit do_hs);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 72'(in_ready16), 72'(1));
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; in_valid16 = 1;
        @(posedge clk);
        #1 in_valid16 = 0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 72'(lat), 72'(4));
        chk({tag, "_sum"}, 72'(sum16), 72'(es));
        chk({tag, "_cout"}, 72'(cout16), 72'(ec));
        chk({tag, "_ovf"}, 72'(ovf16), 72'(eo));
        $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, ta, tb, tc, ts, sum16, cout16, ovf16, lat);
        if (do_hs) begin
            @(negedge clk);
            chk({tag, "_busy_in_done"}, 72'(in_ready16), 72'(0));
            out_ready16 = 1;
            @(posedge clk);
            #1;
            chk({tag, "_ov_fall"}, 72'(out_valid16), 72'(0));
            chk({tag, "_ir_rise"}, 72'(in_ready16), 72'(1));
            out_ready16 = 0;
        end
    endtask

    // Abort the whole run if something hangs.
    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [65:0] e;
        logic [65:0] expq[$];
        int got, cyc, last;
        logic prev;

        // Reset state (sampled while reset is held)
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 72'(in_ready16), 72'(1));
        chk("rst_outputs", 72'({out_valid16, cout16, ovf16, sum16}), 72'(0));
        @(negedge clk) rst_n = 1;

        // Directed arithmetic
        run16("add_basic", 16'h1234, 16'h0FCD, 0, 0, 16'h2201, 0, 0, 1);
        run16("add_ripple", 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);
        run16("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
        run16("sub_neg", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1);
        run16("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1);
        run16("sub_borrow", 16'h0005, 16'h0003, 1, 1, 16'h0001, 1, 0, 1);
        run16("add_basic2", 16'h1234, 16'h0FCD, 0, 0, 16'h2201, 0, 0, 1);

        // Reset in the middle of an operation
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0FCD; cin16 = 0; sub16 = 0; in_valid16 = 1;
        @(posedge clk);
        #1 in_valid16 = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_outputs", 72'({out_valid16, cout16, ovf16, sum16}), 72'(0));
        chk("midrst_in_ready", 72'(in_ready16), 72'(1));
        @(posedge clk);
        #1 rst_n = 1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (out_valid16) seen = 1;
        end
        chk("midrst_no_result", 72'(seen), 72'(0));
        chk("midrst_idle", 72'(in_ready16), 72'(1));
        $display("txn midrst a=1234 b=0fcd aborted out_valid_seen=%0d", seen);

        // Backpressure: result must hold while new operands are offered
        run16("bp", 16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid16 = k[0];
            a16 = 16'($urandom); b16 = 16'($urandom); sub16 = k[1];
            @(posedge clk);
            #1;
            chk("bp_hold", 72'({out_valid16, in_ready16, cout16, ovf16, sum16}),
                72'({1'b1, 1'b0, 1'b0, 1'b0, 16'h3333}));
        end
        @(negedge clk);
        in_valid16 = 0;
        chk("bp_busy", 72'(in_ready16), 72'(0));
        out_ready16 = 1;
        @(posedge clk);
        #1;
        chk("bp_ov_fall", 72'(out_valid16), 72'(0));
        chk("bp_ir_rise", 72'(in_ready16), 72'(1));
        out_ready16 = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (out_valid16) seen = 1;
        end
        chk("bp_no_queue", 72'(seen), 72'(0));
        chk("bp_sum_kept", 72'(sum16), 72'(16'h3333));
        $display("txn bp a=1111 b=2222 held 10 cycles sum=%h", sum16);

        // Exhaustive 4-bit single-pass sweep, latency 1
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            v = 10'(i);
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9]; in_valid4 = 1;
            e = ref_model(4, 64'(v[3:0]), 64'(v[7:4]), v[8], v[9]);
            @(posedge clk);
            #1 in_valid4 = 0;
            @(posedge clk);
            #1;
            chk("sweep4", 72'({out_valid4, ovf4, cout4, sum4}),
                72'({1'b1, e[65], e[64], e[3:0]}));
            $display("txn sweep4 a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                     v[3:0], v[7:4], v[8], v[9], sum4, cout4, ovf4);
            @(posedge clk);
        end

        // 32/8 random stream with both handshakes held open
        got = 0; cyc = 0; last = -1; prev = 0;
        while (got < 10000 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (out_valid32) begin
                if (!prev && last >= 0) chk("period32", 72'(cyc - last), 72'(6));
                if (!prev) last = cyc;
                if (expq.size() == 0) begin
                    chk("stream32_unexpected", 72'(1), 72'(0));
                end else begin
                    e = expq.pop_front();
                    chk("stream32", 72'({ovf32, cout32, sum32}),
                        72'({e[65], e[64], e[31:0]}));
                    $display("txn stream32 #%0d -> sum=%h cout=%0d ovf=%0d",
                             got, sum32, cout32, ovf32);
                end
                got++;
            end
            prev = out_valid32;
            if (in_ready32) begin
                a32 = $urandom; b32 = $urandom;
                cin32 = 1'($urandom); sub32 = 1'($urandom);
                in_valid32 = 1;
                expq.push_back(ref_model(32, 64'(a32), 64'(b32), cin32, sub32));
            end
        end
        in_valid32 = 0;
        chk("stream32_count", 72'(got), 72'(10000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rca_multicycle_addsub.md
Name: rca_multicycle_addsub

Overview:
- Parametrised successor to the team's 4-bit ripple-carry adder. Computes A+B+cin or A-B-cin on WIDTH-bit operands.
- Processes one CHUNK-bit ripple-carry slice per clock and keeps the inter-chunk carry in a register. Wide adders therefore fit a fast clock without a long carry chain.
- Sits between producer and consumer logic in the datapath. Uses a valid/ready handshake on both sides and reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be >= 2 and a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. Must be >= 1. CHUNK == WIDTH gives a single-pass adder.
- NCHUNK, WIDTH/CHUNK, derived. Not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in (add) or borrow-in (sub).
- sub, input, 1, 0 = add, 1 = subtract.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result.
- cout, output, 1, raw carry out of the MSB. In sub mode: 1 = no borrow, 0 = borrow.
- ovf, output, 1, two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, out_valid=0, sum=0, cout=0, ovf=0, chunk counter 0, carry register 0.
  - in_ready is decoded from state, so it reads 1 while in reset.
- Reset asserted mid-operation aborts immediately and discards the operation. No result is produced.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE), combinational from state only.
- IDLE, on in_valid && in_ready at clock edge E0:
  - Register a and (sub ? ~b : b).
  - Set carry = sub ? ~cin : cin.
  - Clear chunk counter. Go to RUN.
  - Effective operation: add = a + b + cin; sub = a + ~b + ~cin = a - b - cin.
- RUN, edge Ei (i = 1..NCHUNK): add chunk i-1 (bits [i*CHUNK-1 : (i-1)*CHUNK]) plus carry.
  - Store the chunk result into the result register.
  - Update carry to that chunk's carry-out.
  - At the last chunk, also capture the carry into the MSB and compute ovf.
  - At E_NCHUNK, drive sum/cout/ovf, set out_valid=1 and go to DONE.
- Latency: out_valid is high in the cycle following edge E_NCHUNK, i.e. NCHUNK edges after acceptance. CHUNK == WIDTH gives latency 1.
- DONE: sum/cout/ovf/out_valid hold stable until out_valid && out_ready.
  - On that edge: out_valid=0, go to IDLE. in_ready rises in the next cycle; no same-cycle turnaround.
- in_valid is ignored in RUN and DONE; no queuing. Operand inputs may change freely after acceptance.
- After the output handshake, sum/cout/ovf keep their last values until overwritten by the next completion.
- Throughput with out_ready held 1 and in_valid held 1: one result per NCHUNK+2 cycles.
- Arithmetic is modulo 2^WIDTH; no saturation.
- ovf is computed identically in add and sub modes from the effective operands.
- Illegal parameters (WIDTH % CHUNK != 0, CHUNK < 1, WIDTH < 2) are an elaboration-time error.

Test Plan:
- Reset mid-operation: accept a=0x1234 b=0x0FCD, assert rst_n=0 at cycle 2 for 1 cycle -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 immediately; no result appears afterwards.
- Basic add (WIDTH=16, CHUNK=4): a=0x1234 b=0x0FCD cin=0 sub=0 -> sum=0x2201, cout=0, ovf=0, out_valid exactly 4 edges after the accepting edge.
- Full-width carry ripple: a=0xFFFF b=0x0000 cin=1 sub=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF b=0x0001 cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract: sub=1 a=0x0005 b=0x0007 cin=0 -> sum=0xFFFE, cout=0, ovf=0. Also sub=1 a=0x8000 b=0x0001 cin=0 -> sum=0x7FFF, cout=1, ovf=1. Also sub=1 a=0x0005 b=0x0003 cin=1 -> sum=0x0001, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; pulse in_valid with new operands meanwhile -> sum/cout/ovf/out_valid stable, in_ready=0, pulses ignored. Raise out_ready -> out_valid falls on that edge, in_ready=1 the following cycle.
- Config sweep: WIDTH=4 CHUNK=4 exhaustive (a, b, cin, sub = 1024 vectors) against a reference model with latency 1. WIDTH=32 CHUNK=8 with 10k random vectors and in_valid/out_ready held 1 -> results correct, period exactly NCHUNK+2 = 6 cycles.
